// File: rtl/fbless_line_mem_arbiter.sv
// Shares one single-port line memory between the raster fetcher (absolute priority)
// and the Wishbone host port, with a sticky host-starvation flag.
module fbless_line_mem_arbiter #(
  parameter int          ADDR_W       = 9,
  parameter logic [31:0] BASE_ADDR    = 32'h3000_0000,
  parameter int          STARVE_LIMIT = 64
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic              wbs_ack_o,
  output logic [31:0]       wbs_dat_o,
  input  logic              pix_req_i,
  input  logic [ADDR_W-1:0] pix_addr_i,
  output logic              pix_valid_o,
  output logic [31:0]       pix_data_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [3:0]        mem_wmask_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic              starve_irq_o,
  input  logic              starve_clr_i
);

  // Handshake: a host request is taken when cyc&stb are seen in IDLE; wbs_ack_o is
  // high for the single ACK-state cycle and only while cyc is still asserted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    RDATA = 2'd2,
    ACK   = 2'd3
  } state_t;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_dat;
  logic [3:0]        lat_sel;
  logic              lat_we;
  logic [7:0]        starve_cnt;
  logic              req, hit, blocked, starve_set;
  logic              unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];
  assign req        = wbs_cyc_i & wbs_stb_i;
  assign hit        = (wbs_adr_i[31:ADDR_W+2] == BASE_ADDR[31:ADDR_W+2]);
  assign blocked    = (state_q == PEND) & wbs_cyc_i & pix_req_i;
  assign starve_set = blocked & (starve_cnt >= LIMIT - 8'd1);
  assign wbs_ack_o  = (state_q == ACK) & wbs_cyc_i;
  assign pix_data_o = mem_rdata_i;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req) state_d = hit ? PEND : ACK;
      PEND: begin
        if (!wbs_cyc_i)      state_d = IDLE;
        else if (!pix_req_i) state_d = lat_we ? ACK : RDATA;
      end
      RDATA:   state_d = ACK;
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster wins every cycle it asks; the host only gets otherwise-idle cycles.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wmask_o = 4'h0;
    mem_addr_o  = '0;
    mem_wdata_o = 32'h0;
    if (pix_req_i) begin
      mem_en_o   = 1'b1;
      mem_addr_o = pix_addr_i;
    end else if (state_q == PEND && wbs_cyc_i) begin
      mem_en_o    = 1'b1;
      mem_we_o    = lat_we;
      mem_wmask_o = lat_we ? lat_sel : 4'h0;
      mem_addr_o  = lat_addr;
      mem_wdata_o = lat_dat;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      lat_addr     <= '0;
      lat_dat      <= 32'h0;
      lat_sel      <= 4'h0;
      lat_we       <= 1'b0;
      wbs_dat_o    <= 32'h0;
      pix_valid_o  <= 1'b0;
      starve_cnt   <= 8'h0;
      starve_irq_o <= 1'b0;
    end else begin
      pix_valid_o <= pix_req_i;
      if (state_q == IDLE && req) begin
        lat_addr <= wbs_adr_i[ADDR_W+1:2];
        lat_dat  <= wbs_dat_i;
        lat_sel  <= wbs_sel_i;
        lat_we   <= wbs_we_i;
        if (!hit) wbs_dat_o <= 32'h0;
      end
      if (state_q == RDATA) wbs_dat_o <= mem_rdata_i;
      // Counts consecutive blocked cycles; any issue or exit from PEND restarts it.
      if (blocked) begin
        if (starve_cnt != LIMIT) starve_cnt <= starve_cnt + 8'd1;
      end else begin
        starve_cnt <= 8'h0;
      end
      if (starve_set)        starve_irq_o <= 1'b1;
      else if (starve_clr_i) starve_irq_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fbless_line_mem_arbiter.sv
// Directed bench for fbless_line_mem_arbiter: host transfers, raster contention,
// starvation flag, miss/abort handling and mid-transfer reset.
module tb_fbless_line_mem_arbiter;

  localparam int          ADDR_W = 9;
  localparam logic [31:0] BASE   = 32'h3000_0000;

  logic              wb_clk_i = 1'b0;
  logic              wb_rst_i;
  logic              wbs_cyc_i, wbs_stb_i, wbs_we_i;
  logic [3:0]        wbs_sel_i;
  logic [31:0]       wbs_adr_i, wbs_dat_i;
  logic              wbs_ack_o;
  logic [31:0]       wbs_dat_o;
  logic              pix_req_i;
  logic [ADDR_W-1:0] pix_addr_i;
  logic              pix_valid_o;
  logic [31:0]       pix_data_o;
  logic              mem_en_o, mem_we_o;
  logic [3:0]        mem_wmask_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic [31:0]       mem_rdata_i = 32'h0;
  logic              starve_irq_o;
  logic              starve_clr_i;

  int n_tests = 0;
  int n_fail  = 0;

  // results captured by wb_xfer
  int          ack_cyc, issue_cyc;
  logic        en_seen, iss_we;
  logic [8:0]  iss_addr;
  logic [3:0]  iss_mask;
  logic [31:0] iss_wdata, rd;
  logic        irq_at [0:15];

  fbless_line_mem_arbiter #(
    .ADDR_W(ADDR_W), .BASE_ADDR(BASE), .STARVE_LIMIT(4)
  ) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .pix_req_i(pix_req_i), .pix_addr_i(pix_addr_i),
    .pix_valid_o(pix_valid_o), .pix_data_o(pix_data_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_wmask_o(mem_wmask_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i),
    .starve_irq_o(starve_irq_o), .starve_clr_i(starve_clr_i)
  );

  // clock / reset
  always #5 wb_clk_i = ~wb_clk_i;

  // line memory model: word i preloaded with 0x1000_0000 + i, 1-cycle read latency
  logic [31:0] mem_model [0:511];
  logic        loaded = 1'b0;
  always @(posedge wb_clk_i) begin
    if (!loaded) begin
      for (int i = 0; i < 512; i++) mem_model[i] <= 32'h1000_0000 + 32'(i);
      loaded <= 1'b1;
    end else if (mem_en_o) begin
      for (int b = 0; b < 4; b++)
        if (mem_we_o && mem_wmask_o[b]) mem_model[mem_addr_o][b*8 +: 8] <= mem_wdata_o[b*8 +: 8];
      mem_rdata_i <= mem_model[mem_addr_o];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One host transfer. Cycle k=1 is the first cycle after the request is sampled.
  // pix_n: raster requests in cycles 1..pix_n; clr_cyc/drop_cyc: cycle to pulse
  // starve_clr_i / drop cyc (0 = never). Gives up after 15 cycles without ack.
  task automatic wb_xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel, input int pix_n, input int clr_cyc,
                         input int drop_cyc);
    ack_cyc = 0; issue_cyc = 0; en_seen = 1'b0; rd = 32'h0;
    iss_we = 1'b0; iss_addr = '0; iss_mask = 4'h0; iss_wdata = 32'h0;
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
    wbs_adr_i = adr;  wbs_dat_i = dat;  wbs_sel_i = sel;
    for (int k = 1; k <= 15 && ack_cyc == 0; k++) begin
      @(negedge wb_clk_i);
      pix_req_i    = (k <= pix_n);
      pix_addr_i   = 9'(100 + k);
      starve_clr_i = (k == clr_cyc);
      if (k == drop_cyc) begin
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
      end
      #1;
      irq_at[k] = starve_irq_o;
      if (mem_en_o && !pix_req_i) begin
        en_seen = 1'b1;
        if (issue_cyc == 0) begin
          issue_cyc = k; iss_we = mem_we_o; iss_addr = mem_addr_o;
          iss_mask = mem_wmask_o; iss_wdata = mem_wdata_o;
        end
      end
      if (k <= pix_n) begin
        check("pix_en", 32'(mem_en_o), 1);
        check("pix_we", 32'(mem_we_o), 0);
        check("pix_addr", 32'(mem_addr_o), 32'(100 + k));
      end
      if (k >= 2 && k <= pix_n + 1) begin
        check("pix_valid", 32'(pix_valid_o), 1);
        check("pix_data", pix_data_o, 32'h1000_0000 + 32'(100 + k - 1));
      end
      if (wbs_ack_o) begin
        ack_cyc = k; rd = wbs_dat_o;
      end
    end
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; pix_req_i = 1'b0; starve_clr_i = 1'b0;
  endtask

  task automatic pulse_clr();
    @(negedge wb_clk_i); starve_clr_i = 1'b1;
    @(negedge wb_clk_i); starve_clr_i = 1'b0;
    #1 check("clr_no_set", 32'(starve_irq_o), 0);
  endtask

  logic bad_ack, bad_en;

  initial begin
    wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    wbs_sel_i = 4'h0; wbs_adr_i = 32'h0; wbs_dat_i = 32'h0;
    pix_req_i = 1'b0; pix_addr_i = '0; starve_clr_i = 1'b0;
    repeat (3) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    #1;
    check("rst_ack", 32'(wbs_ack_o), 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_pix_valid", 32'(pix_valid_o), 0);
    check("rst_mem_en", 32'(mem_en_o), 0);
    check("rst_irq", 32'(starve_irq_o), 0);

    // uncontended full-word write then read
    wb_xfer(1'b1, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    check("wr_issue_cyc", 32'(issue_cyc), 1);
    check("wr_we", 32'(iss_we), 1);
    check("wr_addr", 32'(iss_addr), 4);
    check("wr_mask", 32'(iss_mask), 32'hF);
    check("wr_wdata", iss_wdata, 32'hDEAD_BEEF);
    check("wr_ack_cyc", 32'(ack_cyc), 2);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 0, 0);
    check("rd_issue_cyc", 32'(issue_cyc), 1);
    check("rd_we", 32'(iss_we), 0);
    check("rd_mask", 32'(iss_mask), 0);
    check("rd_ack_cyc", 32'(ack_cyc), 3);
    check("rd_data", rd, 32'hDEAD_BEEF);

    // byte-lane write; write ack leaves the read data register alone
    wb_xfer(1'b1, BASE + 32'h10, 32'h00AA_0000, 4'b0100, 0, 0, 0);
    check("bw_mask", 32'(iss_mask), 32'h4);
    check("bw_ack_cyc", 32'(ack_cyc), 2);
    check("bw_dat_hold", rd, 32'hDEAD_BEEF);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 0, 0);
    check("bw_readback", rd, 32'hDEAA_BEEF);

    // raster holds the port for 5 cycles
    wb_xfer(1'b1, BASE + 32'h20, 32'h1234_5678, 4'hF, 5, 0, 0);
    check("cont_issue_cyc", 32'(issue_cyc), 6);
    check("cont_addr", 32'(iss_addr), 8);
    check("cont_we", 32'(iss_we), 1);
    check("cont_ack_cyc", 32'(ack_cyc), 7);
    check("cont_irq", 32'(starve_irq_o), 1);
    pulse_clr();

    // starvation: limit 4, clear attempted while still blocked
    wb_xfer(1'b0, BASE + 32'h20, 32'h0, 4'hF, 6, 6, 0);
    check("starve_pre", 32'(irq_at[4]), 0);
    check("starve_set", 32'(irq_at[5]), 1);
    check("starve_set_wins", 32'(irq_at[7]), 1);
    check("starve_issue_cyc", 32'(issue_cyc), 7);
    check("starve_ack_cyc", 32'(ack_cyc), 9);
    check("starve_rd", rd, 32'h1234_5678);
    #1 check("starve_sticky", 32'(starve_irq_o), 1);

    // window misses: read returns 0, write dropped, memory untouched
    wb_xfer(1'b0, BASE + (32'd4 << ADDR_W), 32'h0, 4'hF, 0, 0, 0);
    check("miss_rd_ack_cyc", 32'(ack_cyc), 1);
    check("miss_rd_dat", rd, 0);
    check("miss_rd_no_mem", 32'(en_seen), 0);
    wb_xfer(1'b1, BASE + (32'd4 << ADDR_W) + 32'h10, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
    check("miss_wr_ack_cyc", 32'(ack_cyc), 1);
    check("miss_wr_no_mem", 32'(en_seen), 0);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 0, 0);
    check("miss_wr_dropped", rd, 32'hDEAA_BEEF);

    // cyc dropped while pending
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 0, 1);
    check("abort_no_ack", 32'(ack_cyc), 0);
    check("abort_no_mem", 32'(en_seen), 0);
    check("abort_state", 32'(dut.state_q), 0);

    // reset in the middle of a read
    @(negedge wb_clk_i);
    wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_adr_i = BASE + 32'h10;
    @(negedge wb_clk_i);
    @(negedge wb_clk_i);
    #1 check("pre_rst_state", 32'(dut.state_q), 2);
    wb_rst_i = 1'b1;
    #1;
    check("midrst_ack", 32'(wbs_ack_o), 0);
    check("midrst_dat", wbs_dat_o, 0);
    check("midrst_irq", 32'(starve_irq_o), 0);
    check("midrst_mem_en", 32'(mem_en_o), 0);
    wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
    repeat (2) @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    bad_ack = 1'b0; bad_en = 1'b0;
    repeat (4) begin
      @(negedge wb_clk_i);
      #1;
      if (wbs_ack_o) bad_ack = 1'b1;
      if (mem_en_o)  bad_en  = 1'b1;
    end
    check("postrst_no_ack", 32'(bad_ack), 0);
    check("postrst_no_mem", 32'(bad_en), 0);
    wb_xfer(1'b0, BASE + 32'h10, 32'h0, 4'hF, 0, 0, 0);
    check("postrst_rd_ack_cyc", 32'(ack_cyc), 3);
    check("postrst_rd", rd, 32'hDEAA_BEEF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fbless_line_mem_arbiter.md
Name: fbless_line_mem_arbiter

Overview:
- Arbitrates one single-port 32-bit line/tile memory between the raster pixel fetcher of the framebufferless graphics core and the management SoC Wishbone slave port.
- The raster side has absolute priority because it is hard real-time. Wishbone accesses fill idle memory cycles.
- A starvation monitor raises a sticky interrupt when a host access waits too long.
- Sits between the Wishbone slave signals of the graphics core top and the line memory macro.

Parameters:
ADDR_W, 9, memory word-address width; the Wishbone window is 2^ADDR_W words.
BASE_ADDR, 32'h3000_0000, byte base of the window; only bits [31:ADDR_W+2] are compared.
STARVE_LIMIT, 64, number of consecutive blocked PEND cycles before the starve flag sets; must be ≥1 and ≤255.

Ports:
wb_clk_i  in  1  system clock
wb_rst_i  in  1  reset, asynchronous, active-high
wbs_cyc_i  in  1  Wishbone cycle
wbs_stb_i  in  1  Wishbone strobe
wbs_we_i  in  1  Wishbone write enable
wbs_sel_i  in  4  byte selects
wbs_adr_i  in  32  byte address
wbs_dat_i  in  32  write data
wbs_ack_o  out  1  ack, one-cycle pulse
wbs_dat_o  out  32  read data, registered
pix_req_i  in  1  raster fetch request, single cycle per word
pix_addr_i  in  ADDR_W  raster word address
pix_valid_o  out  1  raster data valid
pix_data_o  out  32  raster read data
mem_en_o  out  1  memory enable
mem_we_o  out  1  memory write
mem_wmask_o  out  4  byte write mask
mem_addr_o  out  ADDR_W  memory word address
mem_wdata_o  out  32  memory write data
mem_rdata_i  in  32  memory read data, 1-cycle latency
starve_irq_o  out  1  sticky starvation flag
starve_clr_i  in  1  clears starve_irq_o

Behaviour:
- Reset (async assert, synchronous release on wb_clk_i):
  - All registered outputs go to 0; FSM goes to IDLE; starve counter goes to 0.
  - Reset asserted mid-transaction aborts it with no ack and no further memory access.
- Memory port (combinational mux):
  - When pix_req_i=1: mem_en_o=1, mem_we_o=0, mem_addr_o=pix_addr_i, wmask=0.
  - Otherwise, in PEND with cyc still high: the latched Wishbone request drives the port.
  - Otherwise: mem_en_o=0.
- Raster path: pix_valid_o is pix_req_i delayed by 1 cycle. pix_data_o = mem_rdata_i, passed through. Raster is never stalled.
- Wishbone FSM states: IDLE, PEND, RDATA, ACK.
  - IDLE: when cyc&stb&!ack, latch adr/dat/sel/we.
    - Hit: address bits [31:ADDR_W+2] equal BASE_ADDR's. Go to PEND.
    - Miss: go to ACK with wbs_dat_o=0 and no memory access. Miss writes are dropped.
  - PEND:
    - If cyc=0, abort to IDLE with no access.
    - If pix_req_i=1, stay in PEND.
    - Else issue the access: mem_addr_o=adr[ADDR_W+1:2]. For a write: mem_we_o=1, wmask=sel, wdata=dat, go to ACK. For a read: wmask=0, go to RDATA.
  - RDATA: register mem_rdata_i into wbs_dat_o, go to ACK.
  - ACK: wbs_ack_o=1 for exactly one cycle if cyc=1 (suppressed if cyc dropped), then IDLE. A write ack leaves wbs_dat_o unchanged.
- Uncontended latency, with stb first sampled at edge T:
  - Issue in cycle T+1.
  - Write ack in cycle T+2; read ack in cycle T+3.
  - Each cycle of raster blocking adds 1.
- A new request is not accepted during the ACK cycle, so no back-to-back double ack is possible.
- Starvation monitor:
  - 8-bit counter increments on each PEND cycle with pix_req_i=1.
  - Clears on issue or when leaving PEND. Saturates at STARVE_LIMIT.
  - When it reaches STARVE_LIMIT, starve_irq_o sets and stays set.
  - starve_clr_i clears the flag. Set wins over a simultaneous clear.
  - The monitor does not force a grant.
- Address wrap: word addresses use only ADDR_W bits. No wrap beyond the window, because a miss never touches memory.

Test Plan:
- Reset state: assert wb_rst_i mid-read (state RDATA) → all outputs 0 immediately; after release, no ack and no mem_en_o.
- Uncontended write then read:
  - Write 0xDEADBEEF, sel=4'hF to BASE+0x10 → cycle T+1 shows mem_we_o=1, addr=4; ack at T+2.
  - Read of the same address → ack at T+3 with wbs_dat_o=0xDEADBEEF.
- Byte write: sel=4'b0100, dat=0x00AA0000 → mem_wmask_o=4'b0100; readback shows only byte 2 changed.
- Raster contention: pix_req_i held high 5 cycles during PEND → memory serves pix_addr_i every cycle, pix_valid_o trails by 1; Wishbone issues on the first free cycle; write ack at T+7.
- Starvation: STARVE_LIMIT=4, pix_req_i held 4 cycles in PEND → starve_irq_o=1 on the 4th blocked cycle and stays set after the transfer.
  - starve_clr_i with no simultaneous set → flag 0.
  - starve_clr_i with a simultaneous set → flag stays 1.
- Miss and abort:
  - Read at BASE+(4<<ADDR_W) → ack at T+1, dat=0, mem_en_o never 1.
  - cyc dropped during PEND → no access, no ack, FSM back in IDLE.
